// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle between the execute stage and the ALU.
interface alu_exec_unit_if #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
);
  logic               start_i;
  logic [3:0]         ctrl_i;
  logic [DATA_W-1:0]  src1_i;
  logic [DATA_W-1:0]  src2_i;
  logic [SHAMT_W-1:0] shamt_i;
  logic               busy_o;
  logic               done_o;
  logic [DATA_W-1:0]  result_o;
  logic               zero_o;
  logic               overflow_o;
  modport master (
    output start_i, ctrl_i, src1_i, src2_i, shamt_i,
    input  busy_o, done_o, result_o, zero_o, overflow_o
  );
  modport slave (
    input  start_i, ctrl_i, src1_i, src2_i, shamt_i,
    output busy_o, done_o, result_o, zero_o, overflow_o
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU, single-cycle logic/arith ops and iterative arithmetic right shifts.
module alu_exec_unit #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_exec_unit_if.slave bus
);
  localparam int M = DATA_W - 1;
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t             state;
  logic [DATA_W-1:0]  a, b, sum, diff, res, sh_reg, sh_next;
  logic [SHAMT_W-1:0] count, amt;
  logic [3:0]         ctrl;
  logic               is_shift, slt, ovf;
  assign a    = bus.src1_i;
  assign b    = bus.src2_i;
  assign ctrl = bus.ctrl_i;
  always_comb begin
    sum      = a + b;
    diff     = a - b;
    slt      = $signed(a) < $signed(b);
    is_shift = ctrl[3:1] == 3'b100;
    amt      = ctrl[0] ? a[SHAMT_W-1:0] : bus.shamt_i;
    res      = ctrl == 4'b0000 ? a & b :
               ctrl == 4'b0001 ? a | b :
               ctrl == 4'b0010 ? sum :
               ctrl == 4'b0110 ? diff :
               ctrl == 4'b0111 ? {{M{1'b0}}, slt} :
               is_shift        ? b : '0;
    ovf      = ctrl == 4'b0010 ? (a[M] == b[M] && sum[M] != a[M]) :
               ctrl == 4'b0110 ? (a[M] != b[M] && diff[M] != a[M]) : 1'b0;
    sh_next  = $signed(sh_reg) >>> 1;
  end
  // Zero-count shifts fall through the single-cycle path with res = B.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      sh_reg         <= '0;
      count          <= '0;
      bus.busy_o     <= 1'b0;
      bus.done_o     <= 1'b0;
      bus.result_o   <= '0;
      bus.zero_o     <= 1'b1;
      bus.overflow_o <= 1'b0;
    end else begin
      bus.done_o <= 1'b0;
      if (state == IDLE) begin
        if (bus.start_i && is_shift && amt != '0) begin
          sh_reg     <= b;
          count      <= amt;
          bus.busy_o <= 1'b1;
          state      <= SHIFT;
        end else if (bus.start_i) begin
          bus.result_o   <= res;
          bus.zero_o     <= res == '0;
          bus.overflow_o <= ovf;
          bus.done_o     <= 1'b1;
        end
      end else begin
        sh_reg <= sh_next;
        count  <= count - SHAMT_W'(1);
        if (count == SHAMT_W'(1)) begin
          bus.result_o   <= sh_next;
          bus.zero_o     <= sh_next == '0;
          bus.overflow_o <= 1'b0;
          bus.done_o     <= 1'b1;
          bus.busy_o     <= 1'b0;
          state          <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven vectors plus hand sequences, checked through an expected-result queue.
module tb_alu_exec_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  alu_exec_unit_if #(.DATA_W(32), .SHAMT_W(5)) bus();
  alu_exec_unit #(.DATA_W(32), .SHAMT_W(5)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus));
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          edges;
  } vec_t;
  vec_t vecs[$];
  vec_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input bit sync, input bit push);
    if (sync) @(negedge clk);
    bus.start_i = 1'b1;
    bus.ctrl_i  = v.ctrl;
    bus.src1_i  = v.a;
    bus.src2_i  = v.b;
    bus.shamt_i = v.shamt;
    if (push) sb.push_back(v);
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
  endtask

  // Called #1 after the accepting edge (plus pre already-elapsed busy edges).
  task automatic check_out(input string name, input int pre);
    vec_t e;
    int edges = pre;
    int bc = pre;
    while (!bus.done_o && edges < 64) begin
      if (bus.busy_o) bc++;
      @(posedge clk);
      #1;
      edges++;
    end
    if (!bus.done_o || sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: done_o=%b after %0d edges, %0d expected entries", name, bus.done_o, edges, sb.size());
      if (sb.size() != 0) void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      chk({name, " result"}, bus.result_o, e.res);
      chk({name, " zero"}, 32'(bus.zero_o), 32'(e.zero));
      chk({name, " ovf"}, 32'(bus.overflow_o), 32'(e.ovf));
      chk({name, " latency"}, edges, e.edges);
      chk({name, " busy cycles"}, bc, e.edges);
    end
  endtask

  initial begin
    vec_t v;
    int dcount;
    bus.start_i = 1'b0;
    bus.ctrl_i  = '0;
    bus.src1_i  = '0;
    bus.src2_i  = '0;
    bus.shamt_i = '0;
    vecs.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 5'd0, 32'h80000000, 1'b0, 1'b1, 0});
    vecs.push_back('{4'b0110, 32'h00000005, 32'h00000005, 5'd0, 32'h00000000, 1'b1, 1'b0, 0});
    vecs.push_back('{4'b0111, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000001, 1'b0, 1'b0, 0});
    vecs.push_back('{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 32'hF000F000, 1'b0, 1'b0, 0});
    vecs.push_back('{4'b0001, 32'h000000F0, 32'h0000000F, 5'd0, 32'h000000FF, 1'b0, 1'b0, 0});
    vecs.push_back('{4'b0110, 32'h80000000, 32'h00000001, 5'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 0});
    vecs.push_back('{4'b0111, 32'h7FFFFFFF, 32'h80000000, 5'd0, 32'h00000000, 1'b1, 1'b0, 0});
    vecs.push_back('{4'b0111, 32'h80000000, 32'h7FFFFFFF, 5'd0, 32'h00000001, 1'b0, 1'b0, 0});
    vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'h00000001, 5'd0, 32'h00000000, 1'b1, 1'b0, 0});
    vecs.push_back('{4'b0101, 32'h12345678, 32'h9ABCDEF0, 5'd3, 32'h00000000, 1'b1, 1'b0, 0});
    vecs.push_back('{4'b1000, 32'h00000000, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0, 4});
    vecs.push_back('{4'b1001, 32'h00000020, 32'h12345678, 5'd7, 32'h12345678, 1'b0, 1'b0, 0});
    vecs.push_back('{4'b1001, 32'h0000001F, 32'h40000000, 5'd0, 32'h00000000, 1'b1, 1'b0, 31});
    vecs.push_back('{4'b1000, 32'hFFFFFFFF, 32'h7FFFFFF0, 5'd0, 32'h7FFFFFF0, 1'b0, 1'b0, 0});
    vecs.push_back('{4'b1001, 32'hFFFFFFE1, 32'h80000001, 5'd9, 32'hC0000000, 1'b0, 1'b0, 1});

    #2 rst_n = 1'b0;
    #1;
    chk("reset busy", 32'(bus.busy_o), 32'd0);
    chk("reset done", 32'(bus.done_o), 32'd0);
    chk("reset result", bus.result_o, 32'h0);
    chk("reset zero", 32'(bus.zero_o), 32'd1);
    chk("reset ovf", 32'(bus.overflow_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i], 1'b1, 1'b1);
      check_out($sformatf("vec%0d", i), 0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d done pulse", i), 32'(bus.done_o), 32'd0);
    end

    // A start while shifting must be dropped without disturbing the shift.
    drive('{4'b1000, 32'h0, 32'h80000000, 5'd4, 32'hF8000000, 1'b0, 1'b0, 4}, 1'b1, 1'b1);
    drive('{4'b0010, 32'h1, 32'h1, 5'd0, 32'h2, 1'b0, 1'b0, 0}, 1'b1, 1'b0);
    check_out("ignored start", 1);
    dcount = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done_o) dcount++;
    end
    chk("ignored start extra done", dcount, 0);
    chk("ignored start result held", bus.result_o, 32'hF8000000);

    // Asynchronous reset in the 3rd busy cycle of a 10-step shift.
    drive('{4'b1000, 32'h0, 32'h80000000, 5'd10, 32'h0, 1'b0, 1'b0, 10}, 1'b1, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre-abort busy", 32'(bus.busy_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", 32'(bus.busy_o), 32'd0);
    chk("abort result", bus.result_o, 32'h0);
    chk("abort zero", 32'(bus.zero_o), 32'd1);
    chk("abort done", 32'(bus.done_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (bus.done_o || bus.busy_o) dcount++;
    end
    chk("abort no done after release", dcount, 0);

    // Back-to-back: new start issued in the done_o cycle of the previous op.
    drive('{4'b0010, 32'h2, 32'h3, 5'd0, 32'h5, 1'b0, 1'b0, 0}, 1'b1, 1'b1);
    check_out("b2b first", 0);
    drive('{4'b0001, 32'hF0, 32'h0F, 5'd0, 32'hFF, 1'b0, 1'b0, 0}, 1'b0, 1'b1);
    check_out("b2b second", 0);
    @(posedge clk);
    #1;
    chk("b2b done pulse", 32'(bus.done_o), 32'd0);
    drive('{4'b0101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 1'b0, 0}, 1'b1, 1'b1);
    check_out("unknown code", 0);
    chk("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. Consumes the 4-bit ALU control code produced by the ALU controller, plus the two register operands and the shift amount.
- Produces a registered result, a zero flag and an overflow flag.
- Logical and arithmetic ops complete in one cycle.
- The arithmetic right shifts (sra, srav) run iteratively, one bit per cycle, under a start/busy/done handshake. The datapath stalls on busy_o.

Parameters:
- DATA_W, 32, operand and result width.
- SHAMT_W, 5, shift-count width; must equal log2(DATA_W).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request to begin an operation; sampled only while busy_o=0.
- ctrl_i  in  4  ALU control code.
- src1_i  in  DATA_W  operand A (rs).
- src2_i  in  DATA_W  operand B (rt or immediate).
- shamt_i  in  SHAMT_W  instruction shift amount (sra).
- busy_o  out  1  iterative shift in progress; new starts are ignored.
- done_o  out  1  one-cycle pulse: result_o, zero_o and overflow_o are valid and updated.
- result_o  out  DATA_W  registered result; holds until the next done_o.
- zero_o  out  1  registered; 1 iff result_o==0.
- overflow_o  out  1  registered; signed overflow for add/sub, otherwise 0.

Behaviour:
- Reset (rst_i=0, asynchronous) forces:
  - state=IDLE
  - busy_o=0, done_o=0
  - result_o=0, zero_o=1, overflow_o=0
  - internal count=0
- Control codes:
  - 0000 and: A&B.
  - 0001 or: A|B.
  - 0010 add: A+B, modulo 2^DATA_W.
  - 0110 sub: A-B, modulo 2^DATA_W.
  - 0111 slt: result 1 if signed A<B, else 0.
  - 1000 sra: B>>>shamt_i.
  - 1001 srav: B>>>A[SHAMT_W-1:0].
  - Any other code: result 0, overflow 0, single-cycle.
- Overflow:
  - add: operands share a sign and the sum's sign differs.
  - sub: operands' signs differ and the result's sign differs from A.
  - slt: 0; the comparison uses the true signed relation, not the subtract sign bit.
- FSM has two states, IDLE and SHIFT.
- IDLE, start_i=1 at edge k, single-cycle op (or shift with count 0): result and flags registered at edge k, done_o=1 for the cycle after edge k (latency 1), stay IDLE.
- IDLE, start_i=1 at edge k, shift with count n>0: load shift register with B and count=n, go to SHIFT, busy_o=1 from the cycle after edge k.
- SHIFT: at each edge, shift register arithmetic-right by 1 (sign bit replicated) and count decrements.
  - At the edge where count==1: write result, zero_o and overflow_o=0; pulse done_o; return to IDLE with busy_o=0.
  - Latency for a shift of n is n cycles (edges k+1..k+n); for n=0 it is 1 cycle.
- start_i while busy_o=1: ignored, no queueing. Operands need only be stable at the accepting edge; they are captured there.
- Back-to-back: start_i may be high in the same cycle done_o is high. It is accepted if busy_o=0 in that cycle.
- done_o is a single-cycle pulse; it never stays high two consecutive cycles without a new accepted start.
- result_o, zero_o and overflow_o change only on a done_o cycle or on reset.
- Reset mid-SHIFT: operation aborted, no done_o, outputs take their reset values.

Test Plan:
- Reset, then add A=0x7FFFFFFF B=0x00000001 -> done_o 1 cycle after start; result 0x80000000, overflow_o=1, zero_o=0.
- sub A=5 B=5 -> result 0, zero_o=1, overflow_o=0. Then slt A=0xFFFFFFFF B=1 -> result 1.
- sra B=0x80000000 shamt=4 -> busy_o high 4 cycles, done_o on 4th, result 0xF8000000. start_i pulsed mid-shift with add is ignored and result is unchanged.
- srav A=0x00000020 (count 0) B=0x12345678 -> latency 1, result 0x12345678. srav A=31 B=0x40000000 -> 31 cycles, result 0.
- Assert rst_i low during the 3rd cycle of a 10-cycle sra -> busy_o=0, result_o=0, zero_o=1 immediately; no done_o after release.
- Back-to-back: or 0xF0,0x0F issued in the done_o cycle of a prior add -> accepted; next done_o 1 cycle later with result 0xFF. Unknown code 0101 -> result 0, zero_o=1.
